// File: rtl/delay_counter_arbiter_pkg.sv
// Shared types and defaults for the shared delay-counter arbiter.
package delay_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int CNT_WIDTH_DEF = 4;

endpackage

// File: rtl/delay_counter_arbiter_if.sv
// Requester-side bundle of the shared delay counter: request/accept, abort and completion.
interface delay_counter_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 4,
  parameter int ID_WIDTH  = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*CNT_WIDTH-1:0] req_delay;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         abort;
  logic [NUM_REQ-1:0]           done;
  logic                         busy;
  logic [ID_WIDTH-1:0]          grant_id;
  logic [CNT_WIDTH-1:0]         count_o;

  modport master (
    output req_valid, req_delay, abort,
    input  req_ready, done, busy, grant_id, count_o
  );

  modport slave (
    input  req_valid, req_delay, abort,
    output req_ready, done, busy, grant_id, count_o
  );

endinterface

// File: rtl/delay_counter_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above the pointer, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_valid_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [ID_WIDTH-1:0] grant_idx_o,
  output logic                found_o
);

  logic [ID_WIDTH:0] idx;
  logic              hit;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    hit         = 1'b0;
    idx         = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // one extra bit so ptr+off cannot overflow before the wrap subtract
      idx = {1'b0, ptr_i} + (ID_WIDTH+1)'(off);
      if (idx >= (ID_WIDTH+1)'(NUM_REQ)) begin
        idx = idx - (ID_WIDTH+1)'(NUM_REQ);
      end
      if (!hit && req_valid_i[idx[ID_WIDTH-1:0]]) begin
        hit                             = 1'b1;
        grant_o[idx[ID_WIDTH-1:0]]      = 1'b1;
        grant_idx_o                     = idx[ID_WIDTH-1:0];
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/delay_counter_arbiter.sv
// One down-counting delay counter shared round-robin among NUM_REQ requesters.
// state | meaning
// IDLE  | counter free; req_ready offers the round-robin winner
// COUNT | counter owned by grant_id; counts down to 0, then pulses done
module delay_counter_arbiter
  import delay_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input logic                   clk,
  input logic                   rst_n,
  delay_counter_arbiter_if.slave bus
);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic [ID_WIDTH-1:0]  ptr_q;
  logic [ID_WIDTH-1:0]  ptr_d;
  logic [ID_WIDTH-1:0]  grant_id_q;
  logic [NUM_REQ-1:0]   done_q;

  logic [NUM_REQ-1:0]   win_oh;
  logic [ID_WIDTH-1:0]  win_idx;
  logic                 win_found;
  logic                 accept;
  logic [CNT_WIDTH-1:0] delay_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign delay_arr[g] = bus.req_delay[g*CNT_WIDTH +: CNT_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req_valid_i (bus.req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (win_oh),
    .grant_idx_o (win_idx),
    .found_o     (win_found)
  );

  assign accept  = (state_q == IDLE) && win_found;
  assign count_d = delay_arr[win_idx];
  assign ptr_d   = (win_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      ptr_q      <= '0;
      grant_id_q <= '0;
      done_q     <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            count_q    <= count_d;
            grant_id_q <= win_idx;
            ptr_q      <= ptr_d;
            state_q    <= COUNT;
          end
        end
        COUNT: begin
          // abort has priority over the terminal count, so a late abort suppresses done
          if (bus.abort) begin
            count_q <= '0;
            state_q <= IDLE;
          end else if (count_q == '0) begin
            done_q[grant_id_q] <= 1'b1;
            state_q            <= IDLE;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE) ? win_oh : '0;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == COUNT);
  assign bus.grant_id  = grant_id_q;
  assign bus.count_o   = count_q;

  a_done_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done_q));
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));

endmodule

// File: doc/delay_counter_arbiter.md
Name: delay_counter_arbiter

Overview:
- Shares one down-counting delay counter among NUM_REQ requesters. Each requester asks for a delay of D cycles.
- Arbitration is round-robin. The block loads the counter for the winner and counts it down.
- When the count ends, the block returns a one-cycle done pulse to the owner.
- Sits between control FSMs that need timed waits and the single counter resource, so per-client counters are not needed.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- CNT_WIDTH, 4, counter/delay width in bits; max delay 2^CNT_WIDTH-1
- ID_WIDTH, $clog2(NUM_REQ), width of grant_id

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester request
- req_delay  input  NUM_REQ*CNT_WIDTH  packed delays; requester i uses bits [i*CNT_WIDTH +: CNT_WIDTH]
- req_ready  output  NUM_REQ  one-hot accept; a request is taken when valid&ready is seen at a rising edge
- abort  input  1  cancels the in-flight delay
- done  output  NUM_REQ  registered one-cycle completion pulse to the owner
- busy  output  1  high while the counter is owned (state COUNT)
- grant_id  output  ID_WIDTH  registered index of the current/last owner
- count_o  output  CNT_WIDTH  current counter value

Behaviour:
- Reset (async, rst_n=0), applied immediately and held until release:
  - state=IDLE, count_o=0, rr pointer=0, done=0, busy=0, grant_id=0
  - In-flight delay is dropped; no done is generated.
- State IDLE:
  - req_ready is combinational: one-hot on the first req_valid found searching from the pointer upward with wrap (pointer, pointer+1, ... mod NUM_REQ). It is all-zero if no valid.
  - On an accept edge: count←req_delay[winner], grant_id←winner, pointer←(winner+1) mod NUM_REQ, state→COUNT.
- State COUNT:
  - req_ready=0 for all requesters; busy=1.
  - At each edge: if abort=1, state→IDLE, count←0, no done. Else if count==0, done[grant_id]←1 for one cycle, state→IDLE. Else count←count-1.
- Latency, with the handshake cycle as cycle 0:
  - count_o=D during cycle 1; reaches 0 in cycle D+1.
  - done is high in cycle D+2. Delay 0 gives done in cycle 2.
- Back-to-back: in the cycle done is high the block is in IDLE and may accept a new request (including from the same requester, if it is the pointer winner). No bubble is required.
- Boundary rules:
  - abort and count==0 in the same cycle: abort wins, no done.
  - abort in IDLE is ignored.
  - req_valid dropped before it is accepted: nothing is latched.
  - req_delay is sampled only on the accept edge; later changes have no effect.
  - Pointer wrap-around: after winner NUM_REQ-1 the pointer returns to 0.
  - The pointer advances on every accept, including aborted ones.
- Arithmetic:
  - count is unsigned CNT_WIDTH bits and never decrements below 0.
  - The maximum delay 2^CNT_WIDTH-1 is legal.
- done is never asserted for more than one bit or longer than one cycle.

Decomposition:
- Shared package delay_arb_pkg holds:
  - state enum: IDLE, COUNT
  - default constants: NUM_REQ_DEF=4, CNT_WIDTH_DEF=4
- One sub-module: rr_arbiter.
  - Combinational pick of a one-hot grant from req_valid and the pointer.
  - Pointer register update is kept in the parent.

Test Plan (NUM_REQ=4, CNT_WIDTH=4):
1. Reset mid-count: req 0 with D=9, assert rst_n=0 during cycle 3 → outputs zero immediately, no done ever; after release, req_ready[0] answers a new request.
2. Single request: req_valid=0001, D=3, accepted cycle 0 → count_o 3,2,1,0 in cycles 1-4; done=0001 only in cycle 5; busy high in cycles 1-4.
3. Round-robin: all four valid continuously, D=0 → grants 0,1,2,3,0 in order; each done 2 cycles after its accept; accepts on the done cycles, so no bubble.
4. Pointer wrap and fairness: after grant to 3, only req 1 and 2 valid → req 1 granted first, then 2.
5. Abort collision: D=2 with abort in the cycle count_o=0 → no done, busy drops next cycle; abort in IDLE → no state change.
6. Max delay: D=15 → done exactly 17 cycles after accept; req_delay changed after accept has no effect.
